computer_player: RTL

- Automated opponent for the Tug of War player-vs-computer build.
- Generates single-cycle "button press" pulses that drive the computer-side press input of the light chain, the counterpart of the human key input.
- Decision rate is set by a tick prescaler; press probability is set by a 9-bit difficulty value compared against a 10-bit LFSR.
- A hold-off keeps presses separated so the light chain sees distinct key events.

---
 rtl/computer_player_if.sv | 10 +
 rtl/computer_player.sv | 56 +++++
 2 files changed

// File: rtl/computer_player_if.sv
// Press-generator bus: game-side controls in, press pulse and LFSR debug view out.
interface computer_player_if;
  logic       enable;
  logic [8:0] difficulty;
  logic       press;
  logic [9:0] lfsr_state;

  modport master (output enable, output difficulty, input press, input lfsr_state);
  modport slave  (input enable, input difficulty, output press, output lfsr_state);
endinterface

// File: rtl/computer_player.sv
// Computer opponent for Tug of War: on each prescaler tick, presses with a probability
// set by difficulty vs a 10-bit LFSR, with a tick-counted hold-off between presses.
module computer_player #(
  parameter int TICK_DIV = 16,
  parameter int HOLDOFF  = 2
) (
  input  logic              clk,
  input  logic              reset,
  computer_player_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);

  logic [CNT_W-1:0] tick_cnt;
  logic [9:0]       lfsr;
  logic [HO_W-1:0]  holdoff_cnt;
  logic             press_p1;
  logic             tick;
  logic             want;

  // XNOR feedback keeps all-zeros legal, so the reset value 0 is a valid seed.
  function automatic logic [9:0] lfsr_step(input logic [9:0] s);
    return {s[8:0], ~(s[9] ^ s[6])};
  endfunction

  assign tick = (tick_cnt == CNT_LAST);
  assign want = bus.enable && (holdoff_cnt == '0) && ({1'b0, bus.difficulty} > lfsr);

  // Stage p1: decision registered at the tick edge, giving a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      lfsr        <= '0;
      holdoff_cnt <= '0;
      press_p1    <= 1'b0;
    end else if (tick) begin
      tick_cnt <= '0;
      lfsr     <= lfsr_step(lfsr);
      press_p1 <= want;
      if (want)
        holdoff_cnt <= HO_LOAD;
      else if (holdoff_cnt != '0)
        holdoff_cnt <= holdoff_cnt - HO_W'(1);
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
      press_p1 <= 1'b0;
    end
  end

  assign bus.press      = press_p1;
  assign bus.lfsr_state = lfsr;

endmodule
